ssd_capture: RTL and testbench

Receive-side counterpart of the seven-segment display driver. It watches a multiplexed, active-low segment/anode bus (`ssd_seg`, `ssd_ctl`) and rebuilds the four displayed BCD digits into a 16-bit word. It reports completed frames and malformed patterns. It sits in board-to-board links and self-check harnesses where one design's display scan is read back as data.

---
 rtl/ssd_capture_if.sv | 21 ++
 rtl/ssd_capture.sv | 146 ++++++++++++++
 tb/tb_ssd_capture.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_capture_if.sv
// Bundles the multiplexed seven-segment bus and the recovered-frame results.
// The display side drives the segment/anode lines; the capture block drives the results.
interface ssd_capture_if;
   logic [6:0]  ssd_seg;
   logic [3:0]  ssd_ctl;
   logic [15:0] nums;
   logic        valid;
   logic        frame_done;
   logic        seg_err;
   logic        ctl_err;

   modport master (
      output ssd_seg, ssd_ctl,
      input  nums, valid, frame_done, seg_err, ctl_err
   );

   modport slave (
      input  ssd_seg, ssd_ctl,
      output nums, valid, frame_done, seg_err, ctl_err
   );
endinterface

// File: rtl/ssd_capture.sv
// Rebuilds four BCD digits from an active-low multiplexed seven-segment scan.
// Each bus value is sampled once, after it has been stable for SETTLE_CYCLES edges.
module ssd_capture #(
   parameter int SETTLE_CYCLES = 16
) (
   input logic          clk,
   input logic          rst,
   ssd_capture_if.slave bus
);

   localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   logic [6:0]  seg_q, seg_d;
   logic [3:0]  ctl_q, ctl_d;
   logic [7:0]  stable_cnt_q, stable_cnt_d;
   logic [15:0] shadow_q, shadow_d;
   logic [3:0]  seen_q, seen_d;
   logic [15:0] nums_q, nums_d;
   logic        valid_q, valid_d;
   logic        frame_done_q, frame_done_d;
   logic        seg_err_q, seg_err_d;
   logic        ctl_err_q, ctl_err_d;

   logic        changed;
   logic        sample;
   logic [3:0]  code;
   logic        code_ok;
   logic        one_hot;
   logic        blank;
   logic [1:0]  idx;
   logic [3:0]  seen_next;

   always_comb begin
      code    = 4'h0;
      code_ok = 1'b1;
      unique case (seg_q)
         7'b1000000: code = 4'h0;
         7'b1111001: code = 4'h1;
         7'b0100100: code = 4'h2;
         7'b0110000: code = 4'h3;
         7'b0011001: code = 4'h4;
         7'b0010010: code = 4'h5;
         7'b0000010: code = 4'h6;
         7'b1111000: code = 4'h7;
         7'b0000000: code = 4'h8;
         7'b0010000: code = 4'h9;
         7'b0111111: code = 4'hF;
         default:    code_ok = 1'b0;
      endcase
   end

   always_comb begin
      one_hot = 1'b1;
      blank   = 1'b0;
      idx     = 2'd0;
      unique case (ctl_q)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         4'b1111: begin
            one_hot = 1'b0;
            blank   = 1'b1;
         end
         default: one_hot = 1'b0;
      endcase
   end

   // A change seen by the input stage restarts the settle window; the sample
   // fires only on the count's step into SETTLE_MAX, so a held bus samples once.
   always_comb begin
      seg_d   = bus.ssd_seg;
      ctl_d   = bus.ssd_ctl;
      changed = (seg_d != seg_q) || (ctl_d != ctl_q);
      if (changed)
         stable_cnt_d = 8'd0;
      else if (stable_cnt_q == SETTLE_MAX)
         stable_cnt_d = stable_cnt_q;
      else
         stable_cnt_d = stable_cnt_q + 8'd1;
      sample = !changed && (stable_cnt_q == SETTLE_LAST);
   end

   always_comb begin
      shadow_d     = shadow_q;
      seen_d       = seen_q;
      nums_d       = nums_q;
      valid_d      = valid_q;
      frame_done_d = 1'b0;
      seg_err_d    = 1'b0;
      ctl_err_d    = 1'b0;
      seen_next    = seen_q | (4'b0001 << idx);
      if (sample && !blank) begin
         if (!one_hot) begin
            ctl_err_d = 1'b1;
         end else if (!code_ok) begin
            seg_err_d = 1'b1;
         end else begin
            shadow_d[{idx, 2'b00} +: 4] = code;
            // The completing digit goes straight into nums on this same edge.
            if (seen_next == 4'hF) begin
               nums_d       = shadow_d;
               valid_d      = 1'b1;
               frame_done_d = 1'b1;
               seen_d       = 4'h0;
            end else begin
               seen_d = seen_next;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q        <= 7'h7F;
         ctl_q        <= 4'hF;
         stable_cnt_q <= 8'd0;
         shadow_q     <= 16'h0000;
         seen_q       <= 4'h0;
         nums_q       <= 16'h0000;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         seg_err_q    <= 1'b0;
         ctl_err_q    <= 1'b0;
      end else begin
         seg_q        <= seg_d;
         ctl_q        <= ctl_d;
         stable_cnt_q <= stable_cnt_d;
         shadow_q     <= shadow_d;
         seen_q       <= seen_d;
         nums_q       <= nums_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
         seg_err_q    <= seg_err_d;
         ctl_err_q    <= ctl_err_d;
      end
   end

   assign bus.nums       = nums_q;
   assign bus.valid      = valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.seg_err    = seg_err_q;
   assign bus.ctl_err    = ctl_err_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Self-checking bench for ssd_capture: a bus-level model predicts each sample
// event and queues it; a monitor pops and compares whenever the DUT pulses.
module tb_ssd_capture;

   localparam int SETTLE = 16;
   localparam logic [1:0] EV_FRAME = 2'd0;
   localparam logic [1:0] EV_SEG   = 2'd1;
   localparam logic [1:0] EV_CTL   = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [15:0] nums;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   ev_t  exp_q[$];

   logic [6:0]  seg_tab [0:10];
   logic [15:0] m_shadow;
   logic [3:0]  m_seen;
   logic [15:0] m_nums;
   logic        m_valid;
   logic [6:0]  m_last_seg;
   logic [3:0]  m_last_ctl;
   int          m_run;

   ssd_capture_if bus();

   ssd_capture #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      seg_tab[0]  = 7'b1000000;
      seg_tab[1]  = 7'b1111001;
      seg_tab[2]  = 7'b0100100;
      seg_tab[3]  = 7'b0110000;
      seg_tab[4]  = 7'b0011001;
      seg_tab[5]  = 7'b0010010;
      seg_tab[6]  = 7'b0000010;
      seg_tab[7]  = 7'b1111000;
      seg_tab[8]  = 7'b0000000;
      seg_tab[9]  = 7'b0010000;
      seg_tab[10] = 7'b0111111;
   end

   // Returns {ok, code}; index 10 of the table is the dash, shown as F.
   function automatic logic [4:0] model_decode(input logic [6:0] s);
      logic [4:0] r;
      r = 5'b0_0000;
      for (int d = 0; d < 11; d++)
         if (s == seg_tab[d]) r = {1'b1, (d == 10) ? 4'hF : 4'(d)};
      return r;
   endfunction

   function automatic logic [3:0] ctl_of(input int i);
      logic [3:0] one;
      one = 4'b0001 << i;
      return ~one;
   endfunction

   task automatic model_sample(input logic [6:0] s, input logic [3:0] c);
      logic [4:0] dec;
      int         i;
      ev_t        e;
      i = -1;
      for (int k = 0; k < 4; k++) if (c == ctl_of(k)) i = k;
      if (c == 4'hF) return;
      if (i < 0) begin
         e.kind = EV_CTL; e.nums = 16'h0; exp_q.push_back(e);
         return;
      end
      dec = model_decode(s);
      if (!dec[4]) begin
         e.kind = EV_SEG; e.nums = 16'h0; exp_q.push_back(e);
         return;
      end
      m_shadow[i*4 +: 4] = dec[3:0];
      m_seen[i] = 1'b1;
      if (m_seen == 4'hF) begin
         m_nums  = m_shadow;
         m_valid = 1'b1;
         m_seen  = 4'h0;
         e.kind = EV_FRAME; e.nums = m_shadow; exp_q.push_back(e);
      end
   endtask

   // Drives one bus value for a number of cycles; the model samples it once
   // when its uninterrupted run first reaches SETTLE+1 edges.
   task automatic applyStimulus(input logic [6:0] s, input logic [3:0] c, input int cycles);
      int old_run;
      if (s == m_last_seg && c == m_last_ctl) begin
         old_run = m_run;
      end else begin
         old_run = 0;
      end
      m_run = old_run + cycles;
      m_last_seg = s;
      m_last_ctl = c;
      if (old_run < SETTLE + 1 && m_run >= SETTLE + 1) model_sample(s, c);
      bus.ssd_seg = s;
      bus.ssd_ctl = c;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.ssd_seg = 7'h7F;
      bus.ssd_ctl = 4'hF;
      m_shadow = 16'h0; m_seen = 4'h0; m_nums = 16'h0; m_valid = 1'b0;
      m_last_seg = 7'h7F; m_last_ctl = 4'hF; m_run = 0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_state(input string name);
      total++;
      if (bus.nums !== m_nums) begin
         bad++;
         $display("[TB] FAIL %s nums: got %h expected %h", name, bus.nums, m_nums);
      end
      total++;
      if (bus.valid !== m_valid) begin
         bad++;
         $display("[TB] FAIL %s valid: got %b expected %b", name, bus.valid, m_valid);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL %s drained: got %0d pending events expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Scoreboard monitor: every result pulse must match the next predicted event.
   always @(negedge clk) begin
      ev_t        e;
      logic [1:0] kind;
      if (bus.frame_done || bus.seg_err || bus.ctl_err) begin
         kind = bus.frame_done ? EV_FRAME : (bus.seg_err ? EV_SEG : EV_CTL);
         total++;
         if ($countones({bus.frame_done, bus.seg_err, bus.ctl_err}) > 1) begin
            bad++;
            $display("[TB] FAIL exclusive pulses: got fd=%b se=%b ce=%b expected one", bus.frame_done, bus.seg_err, bus.ctl_err);
         end else if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected event: got kind %0d expected none", kind);
         end else begin
            e = exp_q.pop_front();
            if (kind !== e.kind) begin
               bad++;
               $display("[TB] FAIL event kind: got %0d expected %0d", kind, e.kind);
            end else if (kind == EV_FRAME && bus.nums !== e.nums) begin
               bad++;
               $display("[TB] FAIL frame nums: got %h expected %h", bus.nums, e.nums);
            end
         end
      end
   end

   task automatic test_reset();
      do_reset();
      total++;
      if ({bus.frame_done, bus.seg_err, bus.ctl_err} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL reset pulses: got %b expected 000", {bus.frame_done, bus.seg_err, bus.ctl_err});
      end
      check_state("reset");
   endtask

   task automatic test_full_scan();
      applyStimulus(seg_tab[4], 4'b1110, 40);
      applyStimulus(seg_tab[3], 4'b1101, 40);
      applyStimulus(seg_tab[2], 4'b1011, 40);
      applyStimulus(seg_tab[1], 4'b0111, 40);
      total++;
      if (bus.nums !== 16'h1234) begin
         bad++;
         $display("[TB] FAIL full_scan const: got %h expected 1234", bus.nums);
      end
      check_state("full_scan");
   endtask

   task automatic test_short_hold();
      do_reset();
      for (int i = 0; i < 4; i++) applyStimulus(seg_tab[4 - i], ctl_of(i), 10);
      applyStimulus(7'h7F, 4'hF, SETTLE + 4);
      check_state("short_hold");
   endtask

   task automatic test_seg_err();
      applyStimulus(7'b1111111, 4'b1101, 40);
      check_state("seg_err");
      applyStimulus(seg_tab[4], 4'b1110, 40);
      applyStimulus(seg_tab[3], 4'b1101, 40);
      applyStimulus(seg_tab[2], 4'b1011, 40);
      applyStimulus(seg_tab[1], 4'b0111, 40);
      check_state("seg_err_rescan");
   endtask

   task automatic test_ctl_err();
      applyStimulus(seg_tab[8], 4'b1100, 40);
      applyStimulus(seg_tab[8], 4'b0000, 40);
      check_state("ctl_err");
   endtask

   task automatic test_overwrite();
      applyStimulus(seg_tab[5], 4'b1110, 40);
      applyStimulus(seg_tab[7], 4'b1110, 40);
      for (int i = 1; i < 4; i++) applyStimulus(seg_tab[0], ctl_of(i), 40);
      total++;
      if (bus.nums !== 16'h0007) begin
         bad++;
         $display("[TB] FAIL overwrite const: got %h expected 0007", bus.nums);
      end
      check_state("overwrite");
   endtask

   // Exactly SETTLE edges is too short, SETTLE+1 is just enough; the same
   // segment pattern on a new anode still counts as a fresh value.
   task automatic test_back_to_back();
      applyStimulus(seg_tab[1], 4'b1110, SETTLE);
      applyStimulus(seg_tab[9], 4'b1110, SETTLE + 1);
      applyStimulus(seg_tab[8], 4'b1101, SETTLE + 1);
      applyStimulus(seg_tab[8], 4'b1011, SETTLE + 1);
      applyStimulus(seg_tab[5], 4'b0111, SETTLE + 1);
      applyStimulus(7'h7F, 4'hF, 4);
      check_state("back_to_back");
      applyStimulus(7'h7F, 4'hF, 4 * SETTLE);
      check_state("held_no_repeat");
   endtask

   task automatic test_reset_mid_frame();
      applyStimulus(seg_tab[3], 4'b1110, 40);
      applyStimulus(seg_tab[6], 4'b1101, 40);
      do_reset();
      check_state("mid_reset");
      for (int i = 0; i < 3; i++) applyStimulus(seg_tab[10], ctl_of(i), 40);
      check_state("dash_partial");
      applyStimulus(seg_tab[10], 4'b0111, 40);
      total++;
      if (bus.nums !== 16'hFFFF) begin
         bad++;
         $display("[TB] FAIL dash const: got %h expected FFFF", bus.nums);
      end
      check_state("dash_frame");
   endtask

   initial begin
      bus.ssd_seg = 7'h7F;
      bus.ssd_ctl = 4'hF;
      @(negedge clk);
      test_reset();
      test_full_scan();
      test_short_hold();
      test_seg_err();
      test_ctl_err();
      test_overwrite();
      test_back_to_back();
      test_reset_mid_frame();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
